// File: rtl/switch_input_pkg.sv
// Shared types and constants for the IN-instruction input port.
package switch_input_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLD,
        RELEASE
    } state_t;

endpackage

// File: rtl/switch_input_port_debounce_filter.sv
// Push-button synchronizer and debounce filter; produces the debounced level
// (active-high pressed) and a one-cycle pulse on each accepted press.
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic AutoClock,
    input  logic n_reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Raw button is active-low, so every stage resets to the released level (1).
    always_ff @(posedge AutoClock or negedge n_reset) begin
        if (!n_reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_level = ~stable;
    assign press_evt = stable_d & ~stable;

endmodule

// File: rtl/switch_input_port.sv
// Input port for the IN instruction: waits for a fresh debounced press, captures
// the switches and stalls the core until the word is acked. Option: SWITCH_INPUT_SYNC_EN.
module switch_input_port
    import switch_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DATA_W          = DEFAULT_DATA_W
) (
    input  logic              AutoClock,
    input  logic              n_reset,
    input  logic              Button,
    input  logic [DATA_W-1:0] Switches,
    input  logic              in_req,
    input  logic              in_ack,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              stall,
    output logic              btn_level
);

    state_t            state;
    state_t            state_nxt;
    logic              press_evt;
    logic              capture;
    logic              drop;
    logic [DATA_W-1:0] sw_cap;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .AutoClock(AutoClock),
        .n_reset  (n_reset),
        .btn_raw  (Button),
        .btn_level(btn_level),
        .press_evt(press_evt)
    );

`ifdef SWITCH_INPUT_SYNC_EN
    logic [DATA_W-1:0] sw_s1;
    logic [DATA_W-1:0] sw_s2;

    always_ff @(posedge AutoClock or negedge n_reset) begin
        if (!n_reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= Switches;
            sw_s2 <= sw_s1;
        end
    end

    assign sw_cap = sw_s2;
`else
    // Switches are held static by the operator, so direct sampling is safe.
    assign sw_cap = Switches;
`endif

    always_ff @(posedge AutoClock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        drop      = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                // A press already in progress must be released before it counts.
                if (in_req) begin
                    state_nxt = btn_level ? RELEASE : ARMED;
                end
            end
            ARMED: begin
                stall = 1'b1;
                if (press_evt) begin
                    state_nxt = HOLD;
                    capture   = 1'b1;
                end else if (!in_req) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                stall = ~in_ack;
                if (in_ack || !in_req) begin
                    state_nxt = RELEASE;
                    drop      = 1'b1;
                end
            end
            RELEASE: begin
                if (!btn_level) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AutoClock or negedge n_reset) begin
        if (!n_reset) begin
            in_data  <= '0;
            in_valid <= 1'b0;
        end else if (capture) begin
            in_data  <= sw_cap;
            in_valid <= 1'b1;
        end else if (drop) begin
            in_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port with a cycle-level behavioural model.
module tb_switch_input_port;

    localparam int DC = 4;
    localparam int DW = 16;

    logic          AutoClock = 1'b0;
    logic          n_reset   = 1'b0;
    logic          Button    = 1'b1;
    logic [DW-1:0] Switches  = '0;
    logic          in_req    = 1'b0;
    logic          in_ack    = 1'b0;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          stall;
    logic          btn_level;

    int vectors     = 0;
    int miscompares = 0;

    switch_input_port #(
        .DEBOUNCE_CYCLES(DC),
        .DATA_W         (DW)
    ) dut (
        .AutoClock(AutoClock),
        .n_reset  (n_reset),
        .Button   (Button),
        .Switches (Switches),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .in_valid (in_valid),
        .stall    (stall),
        .btn_level(btn_level)
    );

    always #5 AutoClock = ~AutoClock;

    // Reference model. Button: the level accepted at an edge flips once the last
    // DC synchronized samples (raw delayed two edges) all disagree with it.
    // Port phase: 0 idle, 1 waiting for press, 2 word held, 3 waiting for release.
    bit          m_raw_1 = 1'b1;
    bit          m_raw_2 = 1'b1;
    bit          m_win[$];
    bit          m_stable = 1'b1;
    bit          m_press  = 1'b0;
    int          m_phase  = 0;
    logic [DW-1:0] m_data = '0;
    bit          m_valid  = 1'b0;
    bit          m_synced;
    bit          m_flip;
    bit          m_pressed;

    always @(posedge AutoClock or negedge n_reset) begin
        if (!n_reset) begin
            m_raw_1  = 1'b1;
            m_raw_2  = 1'b1;
            m_win.delete();
            m_stable = 1'b1;
            m_press  = 1'b0;
            m_phase  = 0;
            m_data   = '0;
            m_valid  = 1'b0;
        end else begin
            m_pressed = ~m_stable;
            if (m_phase == 0) begin
                if (in_req) m_phase = m_pressed ? 3 : 1;
            end else if (m_phase == 1) begin
                if (m_press) begin
                    m_phase = 2;
                    m_data  = Switches;
                    m_valid = 1'b1;
                end else if (!in_req) begin
                    m_phase = 0;
                end
            end else if (m_phase == 2) begin
                if (in_ack || !in_req) begin
                    m_phase = 3;
                    m_valid = 1'b0;
                end
            end else begin
                if (!m_pressed) m_phase = 0;
            end
            m_synced = m_raw_2;
            m_raw_2  = m_raw_1;
            m_raw_1  = Button;
            m_win.push_back(m_synced);
            if (m_win.size() > DC) void'(m_win.pop_front());
            m_flip = (m_win.size() == DC);
            foreach (m_win[i]) if (m_win[i] == m_stable) m_flip = 1'b0;
            m_press = m_flip && m_stable;
            if (m_flip) m_stable = ~m_stable;
        end
    end

    function automatic logic [DW+2:0] exp_vec();
        logic exp_stall;
        exp_stall = (m_phase == 1) || (m_phase == 2 && !in_ack);
        return {m_valid, exp_stall, ~m_stable, m_data};
    endfunction

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge AutoClock);
        #1;
        vectors++;
        if ({in_valid, stall, btn_level, in_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {in_valid, stall, btn_level, in_data});
        end
        @(negedge AutoClock);
        n_reset = 1'b1;
        Button  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge AutoClock);
            if (i == 2) Button = 1'b1;
            #1;
            vectors++;
            if (btn_level !== 1'b0 || {in_valid, stall, btn_level, in_data} !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch_reject cyc %0d: got %h want btn_level 0 / %h", i,
                         {in_valid, stall, btn_level, in_data}, exp_vec());
            end
        end
    endtask

    task automatic test_basic_in();
        int first_valid;
        first_valid = -1;
        @(negedge AutoClock);
        in_req   = 1'b1;
        Switches = 16'hA5C3;
        Button   = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge AutoClock);
            #1;
            if (in_valid === 1'b1 && first_valid < 0) first_valid = i;
            vectors++;
            if ({in_valid, stall, btn_level, in_data} !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_in cyc %0d: got %h want %h", i,
                         {in_valid, stall, btn_level, in_data}, exp_vec());
            end
            if (i == 10) Button = 1'b1;
        end
        vectors++;
        if (first_valid != 7 || in_data !== 16'hA5C3 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: got valid at %0d data %h stall %b want 7 a5c3 1",
                     first_valid, in_data, stall);
        end
        @(negedge AutoClock);
        in_ack = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0 || in_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ack_stall: got stall %b valid %b want 0 1", stall, in_valid);
        end
        @(negedge AutoClock);
        in_ack = 1'b0;
        in_req = 1'b0;
        #1;
        vectors++;
        if (in_valid !== 1'b0 || stall !== 1'b0 || in_data !== 16'hA5C3) begin
            miscompares++;
            $display("FAIL basic_after_ack: got valid %b stall %b data %h want 0 0 a5c3",
                     in_valid, stall, in_data);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge AutoClock);
            #1;
            vectors++;
            if ({in_valid, stall, btn_level, in_data} !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_settle cyc %0d: got %h want %h", i,
                         {in_valid, stall, btn_level, in_data}, exp_vec());
            end
        end
    endtask

    task automatic test_held_button();
        @(negedge AutoClock);
        Button = 1'b0;
        repeat (10) @(negedge AutoClock);
        in_req   = 1'b1;
        Switches = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge AutoClock);
            #1;
            vectors++;
            if ({in_valid, stall, btn_level, in_data} !== exp_vec() || in_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL held_no_capture cyc %0d: got %h want %h", i,
                         {in_valid, stall, btn_level, in_data}, exp_vec());
            end
        end
        Button = 1'b1;
        repeat (8) @(negedge AutoClock);
        Switches = 16'h2222;
        Button   = 1'b0;
        repeat (10) @(negedge AutoClock);
        #1;
        vectors++;
        if (in_valid !== 1'b1 || in_data !== 16'h2222 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL held_second_press: got valid %b data %h stall %b want 1 2222 1",
                     in_valid, in_data, stall);
        end
        Button = 1'b1;
        @(negedge AutoClock);
        in_ack = 1'b1;
        @(negedge AutoClock);
        in_ack = 1'b0;
        in_req = 1'b0;
        repeat (10) @(negedge AutoClock);
        #1;
        vectors++;
        if ({in_valid, stall, btn_level, in_data} !== exp_vec()) begin
            miscompares++;
            $display("FAIL held_settle: got %h want %h", {in_valid, stall, btn_level, in_data}, exp_vec());
        end
    endtask

    task automatic test_second_press();
        @(negedge AutoClock);
        in_req   = 1'b1;
        Switches = 16'h0001;
        Button   = 1'b0;
        repeat (10) @(negedge AutoClock);
        Button = 1'b1;
        repeat (8) @(negedge AutoClock);
        Switches = 16'hFFFF;
        Button   = 1'b0;
        repeat (10) @(negedge AutoClock);
        Button = 1'b1;
        repeat (8) @(negedge AutoClock);
        #1;
        vectors++;
        if (in_valid !== 1'b1 || in_data !== 16'h0001 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL second_press_kept: got valid %b data %h stall %b want 1 0001 1",
                     in_valid, in_data, stall);
        end
        @(negedge AutoClock);
        in_ack = 1'b1;
        @(negedge AutoClock);
        in_ack = 1'b0;
        in_req = 1'b0;
        #1;
        vectors++;
        if ({in_valid, stall, btn_level, in_data} !== exp_vec()) begin
            miscompares++;
            $display("FAIL second_press_ack: got %h want %h", {in_valid, stall, btn_level, in_data}, exp_vec());
        end
        repeat (4) @(negedge AutoClock);
    endtask

    task automatic test_req_drop();
        logic [DW-1:0] prev_data;
        @(negedge AutoClock);
        in_req = 1'b1;
        repeat (3) @(negedge AutoClock);
        #1;
        vectors++;
        if (stall !== 1'b1 || in_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop_armed: got stall %b valid %b want 1 0", stall, in_valid);
        end
        in_req = 1'b0;
        @(negedge AutoClock);
        #1;
        vectors++;
        if (stall !== 1'b0 || in_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop_idle: got stall %b valid %b want 0 0", stall, in_valid);
        end
        prev_data = m_data;
        in_ack = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0 || in_valid !== 1'b0 || in_data !== prev_data) begin
            miscompares++;
            $display("FAIL ack_in_idle: got stall %b valid %b data %h want 0 0 %h",
                     stall, in_valid, in_data, prev_data);
        end
        @(negedge AutoClock);
        in_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge AutoClock);
            #1;
            vectors++;
            if ({in_valid, stall, btn_level, in_data} !== exp_vec()) begin
                miscompares++;
                $display("FAIL req_drop_settle cyc %0d: got %h want %h", i,
                         {in_valid, stall, btn_level, in_data}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_in_hold();
        @(negedge AutoClock);
        in_req   = 1'b1;
        Switches = 16'hBEEF;
        Button   = 1'b0;
        repeat (10) @(negedge AutoClock);
        Button = 1'b1;
        #1;
        vectors++;
        if (in_valid !== 1'b1 || in_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL hold_before_reset: got valid %b data %h want 1 beef", in_valid, in_data);
        end
        #1;
        n_reset = 1'b0;
        #1;
        vectors++;
        if ({in_valid, stall, btn_level, in_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_hold: got %h want 0", {in_valid, stall, btn_level, in_data});
        end
        @(negedge AutoClock);
        n_reset = 1'b1;
        @(negedge AutoClock);
        #1;
        vectors++;
        if (stall !== 1'b1 || in_valid !== 1'b0 || {in_valid, stall, btn_level, in_data} !== exp_vec()) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h want %h (stall 1)",
                     {in_valid, stall, btn_level, in_data}, exp_vec());
        end
        in_req = 1'b0;
        repeat (2) @(negedge AutoClock);
    endtask

    task automatic test_random();
        int btn_run;
        bit ack_prev;
        btn_run  = 0;
        ack_prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge AutoClock);
            if (btn_run == 0) begin
                Button  = 1'($urandom_range(0, 1));
                btn_run = $urandom_range(1, 8);
            end
            btn_run--;
            Switches = 16'($urandom);
            if (ack_prev) in_req = 1'b0;
            else if (!in_req && $urandom_range(0, 5) == 0) in_req = 1'b1;
            else if (in_req && $urandom_range(0, 49) == 0) in_req = 1'b0;
            in_ack   = m_valid && ($urandom_range(0, 3) == 0);
            ack_prev = in_ack;
            #1;
            vectors++;
            if ({in_valid, stall, btn_level, in_data} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", i,
                         {in_valid, stall, btn_level, in_data}, exp_vec());
            end
        end
        @(negedge AutoClock);
        in_ack = 1'b0;
        in_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_in();
        test_held_button();
        test_second_press();
        test_req_drop();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
